mem_burst_sequencer: RTL

//  Command-driven burst master for the 19-bit word-addressed data memory.

---
 rtl/mem_burst_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_burst_sequencer.sv
// Command-driven burst master for a word-addressed memory: one read or write burst per command.
// Optional macro MEM_SEQ_RANGE_CHECK_EN rejects bursts that would run past the top of memory.
module mem_burst_sequencer #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DRAIN, S_DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cur, cur_n;
  logic [LEN_W-1:0]    rem, rem_n;
  logic                re_n, we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic [RD_LAT:1]     vld_pipe;
  logic                oor;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign wr_ready  = (state == S_WRITE);

`ifdef MEM_SEQ_RANGE_CHECK_EN
  logic [ADDR_W:0] end_addr;
  logic            rng_err;

  // One extra bit so start+len lands exactly on 2**ADDR_W without wrapping.
  assign end_addr = {1'b0, cmd_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, cmd_len};
  assign oor      = end_addr > {1'b1, {ADDR_W{1'b0}}};
  assign err      = done & rng_err;

  always_ff @(posedge clk) begin
    if (rst)                         rng_err <= 1'b0;
    else if (cmd_valid && cmd_ready) rng_err <= oor;
  end
`else
  assign oor = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cur_n   = cur;
    rem_n   = rem;
    re_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = mem_address;
    wdata_n = mem_wdata;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_n = cmd_addr;
          rem_n = cmd_len;
          if (oor || cmd_len == '0) begin
            state_n = S_DONE;
          end else if (cmd_write) begin
            state_n = S_WRITE;
          end else begin
            // First read strobe goes out in the cycle right after accept.
            state_n = S_READ;
            re_n    = 1'b1;
            addr_n  = cmd_addr;
            cur_n   = cmd_addr + 1'b1;
            rem_n   = cmd_len - 1'b1;
          end
        end
      end
      S_READ: begin
        if (rem != '0) begin
          re_n   = 1'b1;
          addr_n = cur;
          cur_n  = cur + 1'b1;
          rem_n  = rem - 1'b1;
        end else begin
          state_n = S_DRAIN;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          we_n    = 1'b1;
          addr_n  = cur;
          wdata_n = wr_data;
          cur_n   = cur + 1'b1;
          rem_n   = rem - 1'b1;
          // Last beat: pass through DRAIN so done lands after the final strobe.
          if (rem == LEN_W'(1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_pipe == '0) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cur              <= '0;
      rem              <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_wdata        <= '0;
      vld_pipe         <= '0;
      rd_valid         <= 1'b0;
      rd_data          <= '0;
    end else begin
      state            <= state_n;
      cur              <= cur_n;
      rem              <= rem_n;
      mem_read_enable  <= re_n;
      mem_write_enable <= we_n;
      mem_address      <= addr_n;
      mem_wdata        <= wdata_n;
      // vld_pipe[k] marks a strobe issued k cycles ago; stage RD_LAT sees valid mem_rdata.
      vld_pipe[1]      <= mem_read_enable;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      rd_valid         <= vld_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) rd_data <= mem_rdata;
    end
  end

endmodule
